// File: rtl/io_pad_power_seq.sv
// Power sequencer for the IO pad ring: debounces the IO supply, staggers pad driver
// group enables up and down, and tristates all drivers at once on supply loss.
// Optional FAULT-entry counter output enabled by defining IOPAD_SEQ_FAULT_CNT_EN.
module io_pad_power_seq #(
    parameter int unsigned N_GROUPS       = 4,
    parameter int unsigned DEB_CYCLES     = 16,
    parameter int unsigned STAGGER_CYCLES = 8
) (
    input  logic                ck,
    input  logic                reset,
    input  logic                iovdd_ok,
    input  logic                en_req,
    input  logic                fault_clr,
    output logic                pad_ngate,
    output logic [N_GROUPS-1:0] grp_en,
    output logic                ready,
    output logic                fault,
    output logic [2:0]          state
`ifdef IOPAD_SEQ_FAULT_CNT_EN
    ,
    output logic [7:0]          fault_cnt
`endif
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned IDX_W = $clog2(N_GROUPS) + 1;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] STG_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_GROUPS - 1);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_DEBOUNCE = 3'd1,
        S_RAMP     = 3'd2,
        S_ON       = 3'd3,
        S_DOWN     = 3'd4,
        S_FAULT    = 3'd5
    } state_t;

    state_t cur;
    state_t nxt;

    logic                sync1;
    logic                ok_s;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_nxt;
    logic [N_GROUPS-1:0] grp_en_nxt;
    logic [N_GROUPS-1:0] grp_clr;
    logic                pad_ngate_nxt;
    logic                ready_nxt;
    logic                fault_nxt;
    logic                fault_entry;

    assign state       = cur;
    assign fault_entry = (nxt == S_FAULT) && (cur != S_FAULT);

    // iovdd_ok arrives asynchronously from the supply monitor
    always_ff @(posedge ck) begin
        if (reset) begin
            sync1 <= 1'b0;
            ok_s  <= 1'b0;
        end else begin
            sync1 <= iovdd_ok;
            ok_s  <= sync1;
        end
    end

    // State register together with the registered outputs and counters
    always_ff @(posedge ck) begin
        if (reset) begin
            cur       <= S_OFF;
            cnt       <= '0;
            idx       <= '0;
            pad_ngate <= 1'b1;
            grp_en    <= '0;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            cur       <= nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            pad_ngate <= pad_ngate_nxt;
            grp_en    <= grp_en_nxt;
            ready     <= ready_nxt;
            fault     <= fault_nxt;
        end
    end

    // Highest enabled group removed; enables always form a contiguous run from bit 0
    always_comb begin
        logic found;
        grp_clr = grp_en;
        found   = 1'b0;
        for (int i = int'(N_GROUPS) - 1; i >= 0; i--) begin
            if (!found && grp_en[i]) begin
                grp_clr[i] = 1'b0;
                found      = 1'b1;
            end
        end
    end

    // Next-state: supply loss beats en_req drop beats counter events
    always_comb begin
        nxt     = cur;
        cnt_nxt = cnt;
        idx_nxt = idx;
        case (cur)
            S_OFF: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                if (en_req && ok_s && !fault) begin
                    nxt = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (!ok_s || !en_req) begin
                    nxt     = S_OFF;
                    cnt_nxt = '0;
                end else if (cnt == DEB_LAST) begin
                    nxt     = S_RAMP;
                    cnt_nxt = '0;
                    idx_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_RAMP: begin
                if (!ok_s) begin
                    nxt     = S_FAULT;
                    cnt_nxt = '0;
                    idx_nxt = '0;
                end else if (!en_req) begin
                    nxt     = S_DOWN;
                    cnt_nxt = '0;
                end else if (cnt == STG_LAST) begin
                    cnt_nxt = '0;
                    idx_nxt = idx + IDX_W'(1);
                    if (idx == IDX_LAST) begin
                        nxt = S_ON;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_ON: begin
                if (!ok_s) begin
                    nxt     = S_FAULT;
                    cnt_nxt = '0;
                end else if (!en_req) begin
                    nxt     = S_DOWN;
                    cnt_nxt = '0;
                end
            end
            S_DOWN: begin
                if (!ok_s) begin
                    nxt     = S_FAULT;
                    cnt_nxt = '0;
                end else if (grp_en == '0) begin
                    nxt     = S_OFF;
                    cnt_nxt = '0;
                end else if (cnt == STG_LAST) begin
                    cnt_nxt = '0;
                    if (grp_clr == '0) begin
                        nxt = S_OFF;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_FAULT: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                if (!en_req) begin
                    nxt = S_OFF;
                end
            end
            default: begin
                nxt     = S_OFF;
                cnt_nxt = '0;
                idx_nxt = '0;
            end
        endcase
    end

    // Output next-values derived from the transition being taken
    always_comb begin
        pad_ngate_nxt = !((nxt == S_RAMP) || (nxt == S_ON) || (nxt == S_DOWN));
        ready_nxt     = (nxt == S_ON);
        fault_nxt     = fault_entry ? 1'b1 : (fault && !fault_clr);
        grp_en_nxt    = grp_en;
        if ((nxt == S_OFF) || (nxt == S_DEBOUNCE) || (nxt == S_FAULT)) begin
            grp_en_nxt = '0;
        end else if ((cur == S_RAMP) && (nxt != S_DOWN) && (cnt == STG_LAST)) begin
            grp_en_nxt = grp_en | (N_GROUPS'(1) << idx);
        end else if ((cur == S_DOWN) && (cnt == STG_LAST)) begin
            grp_en_nxt = grp_clr;
        end
    end

`ifdef IOPAD_SEQ_FAULT_CNT_EN
    // Saturating count of FAULT entries; survives fault_clr
    always_ff @(posedge ck) begin
        if (reset) begin
            fault_cnt <= 8'd0;
        end else if (fault_entry && (fault_cnt != 8'hFF)) begin
            fault_cnt <= fault_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_io_pad_power_seq.sv
// Directed bench for io_pad_power_seq: table-driven power-up/power-down vectors plus
// hand-written glitch, supply-loss, abort, and reset sequences.
module tb_io_pad_power_seq;

    logic       ck;
    logic       reset;
    logic       iovdd_ok;
    logic       en_req;
    logic       fault_clr;
    logic       pad_ngate;
    logic [3:0] grp_en;
    logic       ready;
    logic       fault;
    logic [2:0] state;
`ifdef IOPAD_SEQ_FAULT_CNT_EN
    logic [7:0] fault_cnt;
`endif

    int total = 0;
    int bad   = 0;

    io_pad_power_seq #(
        .N_GROUPS      (4),
        .DEB_CYCLES    (16),
        .STAGGER_CYCLES(8)
    ) dut (
        .ck       (ck),
        .reset    (reset),
        .iovdd_ok (iovdd_ok),
        .en_req   (en_req),
        .fault_clr(fault_clr),
        .pad_ngate(pad_ngate),
        .grp_en   (grp_en),
        .ready    (ready),
        .fault    (fault),
        .state    (state)
`ifdef IOPAD_SEQ_FAULT_CNT_EN
        ,
        .fault_cnt(fault_cnt)
`endif
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    typedef struct {
        int         phase;
        int         edge_n;
        logic [2:0] st;
        logic       png;
        logic [3:0] ge;
        logic       rdy;
        logic       flt;
    } vec_t;

    vec_t vecs[16];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ck);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [2:0] st, input logic png,
                             input logic [3:0] ge, input logic rdy, input logic flt);
        check({name, "_state"}, 32'(state), 32'(st));
        check({name, "_pad_ngate"}, 32'(pad_ngate), 32'(png));
        check({name, "_grp_en"}, 32'(grp_en), 32'(ge));
        check({name, "_ready"}, 32'(ready), 32'(rdy));
        check({name, "_fault"}, 32'(fault), 32'(flt));
    endtask

    initial begin
        int edge_cnt;
        int prev_phase;

        // phase 0: power-up from OFF; phase 1: power-down from ON
        vecs[0]  = '{0,  1, 3'd1, 1'b1, 4'b0000, 1'b0, 1'b0};
        vecs[1]  = '{0, 16, 3'd1, 1'b1, 4'b0000, 1'b0, 1'b0};
        vecs[2]  = '{0, 17, 3'd2, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[3]  = '{0, 24, 3'd2, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[4]  = '{0, 25, 3'd2, 1'b0, 4'b0001, 1'b0, 1'b0};
        vecs[5]  = '{0, 33, 3'd2, 1'b0, 4'b0011, 1'b0, 1'b0};
        vecs[6]  = '{0, 41, 3'd2, 1'b0, 4'b0111, 1'b0, 1'b0};
        vecs[7]  = '{0, 48, 3'd2, 1'b0, 4'b0111, 1'b0, 1'b0};
        vecs[8]  = '{0, 49, 3'd3, 1'b0, 4'b1111, 1'b1, 1'b0};
        vecs[9]  = '{1,  1, 3'd4, 1'b0, 4'b1111, 1'b0, 1'b0};
        vecs[10] = '{1,  8, 3'd4, 1'b0, 4'b1111, 1'b0, 1'b0};
        vecs[11] = '{1,  9, 3'd4, 1'b0, 4'b0111, 1'b0, 1'b0};
        vecs[12] = '{1, 17, 3'd4, 1'b0, 4'b0011, 1'b0, 1'b0};
        vecs[13] = '{1, 25, 3'd4, 1'b0, 4'b0001, 1'b0, 1'b0};
        vecs[14] = '{1, 32, 3'd4, 1'b0, 4'b0001, 1'b0, 1'b0};
        vecs[15] = '{1, 33, 3'd0, 1'b1, 4'b0000, 1'b0, 1'b0};

        reset     = 1'b1;
        iovdd_ok  = 1'b0;
        en_req    = 1'b0;
        fault_clr = 1'b0;
        tick(2);
        check_all("reset", 3'd0, 1'b1, 4'b0000, 1'b0, 1'b0);
`ifdef IOPAD_SEQ_FAULT_CNT_EN
        check("reset_fault_cnt", 32'(fault_cnt), 32'd0);
`endif
        reset    = 1'b0;
        iovdd_ok = 1'b1;
        tick(5);
        check_all("idle_off", 3'd0, 1'b1, 4'b0000, 1'b0, 1'b0);

        // Table: edge 0 is the edge just before en_req changes
        prev_phase = -1;
        edge_cnt   = 0;
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].phase != prev_phase) begin
                en_req     = (vecs[i].phase == 0);
                edge_cnt   = 0;
                prev_phase = vecs[i].phase;
            end
            while (edge_cnt < vecs[i].edge_n) begin
                tick(1);
                edge_cnt++;
            end
            check_all($sformatf("v%0d_p%0d_e%0d", i, vecs[i].phase, vecs[i].edge_n),
                      vecs[i].st, vecs[i].png, vecs[i].ge, vecs[i].rdy, vecs[i].flt);
        end

        // Debounce glitch at cnt=10: back to OFF, then a full fresh count
        en_req = 1'b1;
        tick(11);
        iovdd_ok = 1'b0;
        tick(1);
        iovdd_ok = 1'b1;
        tick(1);
        check_all("glitch_e13", 3'd1, 1'b1, 4'b0000, 1'b0, 1'b0);
        tick(1);
        check_all("glitch_e14", 3'd0, 1'b1, 4'b0000, 1'b0, 1'b0);
        tick(1);
        check_all("glitch_e15", 3'd1, 1'b1, 4'b0000, 1'b0, 1'b0);
        tick(15);
        check_all("glitch_e30", 3'd1, 1'b1, 4'b0000, 1'b0, 1'b0);
        tick(1);
        check_all("glitch_e31", 3'd2, 1'b0, 4'b0000, 1'b0, 1'b0);
        tick(32);
        check_all("glitch_on", 3'd3, 1'b0, 4'b1111, 1'b1, 1'b0);

        // Supply loss in ON; fault_clr coinciding with the fault edge loses
        iovdd_ok = 1'b0;
        tick(2);
        check_all("loss_e2", 3'd3, 1'b0, 4'b1111, 1'b1, 1'b0);
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        check_all("loss_e3", 3'd5, 1'b1, 4'b0000, 1'b0, 1'b1);
        iovdd_ok = 1'b1;
        en_req   = 1'b0;
        tick(1);
        check_all("fault_exit", 3'd0, 1'b1, 4'b0000, 1'b0, 1'b1);
        en_req = 1'b1;
        tick(3);
        check_all("fault_blocks", 3'd0, 1'b1, 4'b0000, 1'b0, 1'b1);
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        check_all("fault_clr", 3'd0, 1'b1, 4'b0000, 1'b0, 1'b0);
        tick(1);
        check_all("restart", 3'd1, 1'b1, 4'b0000, 1'b0, 1'b0);

        // Abort mid-ramp after two groups are up
        en_req = 1'b0;
        tick(1);
        check_all("abort_off", 3'd0, 1'b1, 4'b0000, 1'b0, 1'b0);
        en_req = 1'b1;
        tick(33);
        check_all("abort_ramp", 3'd2, 1'b0, 4'b0011, 1'b0, 1'b0);
        en_req = 1'b0;
        tick(1);
        check_all("abort_down", 3'd4, 1'b0, 4'b0011, 1'b0, 1'b0);
        tick(7);
        check_all("abort_d7", 3'd4, 1'b0, 4'b0011, 1'b0, 1'b0);
        tick(1);
        check_all("abort_d8", 3'd4, 1'b0, 4'b0001, 1'b0, 1'b0);
        tick(7);
        check_all("abort_d15", 3'd4, 1'b0, 4'b0001, 1'b0, 1'b0);
        tick(1);
        check_all("abort_d16", 3'd0, 1'b1, 4'b0000, 1'b0, 1'b0);

        // Synchronous reset in RAMP; synchronizer also restarts from 0
        en_req = 1'b1;
        tick(41);
        check_all("pre_reset", 3'd2, 1'b0, 4'b0111, 1'b0, 1'b0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_all("mid_reset", 3'd0, 1'b1, 4'b0000, 1'b0, 1'b0);
        tick(1);
        check_all("post_reset_1", 3'd0, 1'b1, 4'b0000, 1'b0, 1'b0);
        tick(1);
        check_all("post_reset_2", 3'd0, 1'b1, 4'b0000, 1'b0, 1'b0);
        tick(1);
        check_all("post_reset_3", 3'd1, 1'b1, 4'b0000, 1'b0, 1'b0);

`ifdef IOPAD_SEQ_FAULT_CNT_EN
        // Induce 300 faults from RAMP; counter saturates at 255
        for (int k = 0; k < 300; k++) begin
            fault_clr = 1'b1;
            iovdd_ok  = 1'b1;
            en_req    = 1'b1;
            tick(1);
            fault_clr = 1'b0;
            tick(21);
            iovdd_ok = 1'b0;
            tick(4);
            en_req = 1'b0;
            tick(1);
            if (k == 0) begin
                check("fault_cnt_first", 32'(fault_cnt), 32'd1);
            end
        end
        check("fault_cnt_sat", 32'(fault_cnt), 32'd255);
        check("fault_sticky", 32'(fault), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_pad_power_seq.md
Name: io_pad_power_seq

Overview:
- Sequences the IO pad ring of the Sky130 IO library through power-up and power-down.
- Gates all pad output drivers off (pad_ngate high) until the IO supply is debounced good, then enables pad driver groups one at a time with a stagger delay to limit simultaneous switching current.
- Tristates everything immediately on supply loss.
- Sits between the chip-level power-management logic and the pad-ring driver enables.

Parameters:
- N_GROUPS, 4, number of pad driver groups (1..16); grp_en width.
- DEB_CYCLES, 16, consecutive cycles iovdd_ok must be high before ramp (2..255).
- STAGGER_CYCLES, 8, cycles between successive group enables/disables (1..255).

Ports:
- ck  in  1  clock
- reset  in  1  synchronous, active-high reset
- iovdd_ok  in  1  IO supply good; asynchronous, synchronized internally
- en_req  in  1  request pad ring on (level)
- fault_clr  in  1  one-cycle pulse, clears sticky fault
- pad_ngate  out  1  1 = all pad drivers gated off
- grp_en  out  N_GROUPS  per-group driver enable
- ready  out  1  all groups enabled
- fault  out  1  sticky supply-loss flag
- state  out  3  encoded FSM state

Behaviour:
- One clock (ck). Reset is synchronous and active-high (reset). All outputs registered.
- Reset values: state=OFF, pad_ngate=1, grp_en=0, ready=0, fault=0, internal counters/index=0, sync flops=0.
- iovdd_ok passes a 2-flop synchronizer → ok_s (2-cycle latency). All rules below use ok_s.
- State encoding: OFF=0, DEBOUNCE=1, RAMP=2, ON=3, DOWN=4, FAULT=5.
- OFF: pad_ngate=1, grp_en=0. en_req & ok_s & !fault → DEBOUNCE, cnt=0.
- DEBOUNCE:
  - cnt increments each cycle.
  - !ok_s → OFF (no fault).
  - !en_req → OFF.
  - cnt==DEB_CYCLES-1 with ok_s → RAMP, cnt=0, idx=0, pad_ngate←0 on that edge.
- RAMP:
  - cnt counts 0..STAGGER_CYCLES-1. At cnt==STAGGER_CYCLES-1: grp_en[idx]←1, idx++, cnt=0.
  - When the bit set is idx==N_GROUPS-1: → ON and ready←1 on the same edge.
  - Group k enables (k+1)*STAGGER_CYCLES cycles after RAMP entry.
- ON: ready=1, grp_en all ones, pad_ngate=0. !en_req → DOWN, ready←0, cnt=0.
- RAMP with !en_req → DOWN, keeping current grp_en, cnt=0.
- DOWN:
  - Every STAGGER_CYCLES cycles, clear the highest set grp_en bit.
  - When bit 0 is cleared (or grp_en already 0): → OFF and pad_ngate←1 on the same edge.
  - en_req reasserting during DOWN is ignored until OFF is reached; restart then proceeds normally.
- Supply loss: !ok_s in RAMP, ON or DOWN → FAULT on the next edge. grp_en←0, pad_ngate←1, ready←0, fault←1, all on that edge (no stagger).
- FAULT: outputs held off. Exits to OFF when en_req==0.
- fault: sticky. Cleared only by fault_clr or reset.
  - fault_clr in the same cycle as a new fault event: set wins.
  - While fault=1, OFF does not leave to DEBOUNCE.
- Priority per cycle: reset > supply loss > en_req drop > counter events.
- Reset mid-operation (any state): synchronous return to reset values on the next edge.
- Counter widths: 8 bits. idx width: clog2(N_GROUPS)+1.

Optional Feature:
- Macro: IOPAD_SEQ_FAULT_CNT_EN.
- Defined: adds output fault_cnt [7:0], counting FAULT entries. Saturates at 255. Reset to 0. Not cleared by fault_clr.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan (N_GROUPS=4, DEB_CYCLES=16, STAGGER_CYCLES=8):
- Power-up: iovdd_ok=1 held ≥3 cycles, then en_req=1 at edge 0.
  - state=DEBOUNCE at edge 1.
  - pad_ngate=0 at edge 17.
  - grp_en = 0001/0011/0111/1111 at edges 25/33/41/49.
  - ready=1 and state=ON at edge 49.
- Debounce glitch: from OFF with en_req=1, iovdd_ok drops for 1 cycle at debounce cnt=10 → state OFF, fault=0; then re-enters DEBOUNCE and completes with a full 16-cycle count.
- Power-down: from ON, en_req=0 at edge 0.
  - ready=0 at edge 1.
  - grp_en = 0111/0011/0001/0000 at edges 9/17/25/33.
  - pad_ngate=1 and state=OFF at edge 33.
- Supply loss in ON: iovdd_ok=0 → 3 edges later grp_en=0, pad_ngate=1, fault=1, state=FAULT.
  - en_req=0 → OFF.
  - en_req=1 without fault_clr → stays OFF.
  - fault_clr pulse then en_req=1 → DEBOUNCE.
- Abort mid-ramp: en_req=0 after grp_en=0011 → DOWN; grp_en=0001 8 cycles later, 0000 and OFF 8 cycles after that.
- Reset in RAMP (grp_en=0111): reset=1 for one cycle → next edge all outputs at reset values; with IOPAD_SEQ_FAULT_CNT_EN, 300 induced faults → fault_cnt=255.
